pc_sequencer: RTL

Parametrised fetch-stage next-PC sequencer. It registers the fetch PC and picks each next PC from, in priority order: N prioritised redirect channels (trap, mispredict, jump conflict, ...), a redirect held over a stall, a return-address stack, the predictor target, or the sequential increment. Unlike a purely combinational next-PC mux, it does not lose redirects that arrive during a fetch stall. It sits between the branch/exception logic of later stages and the instruction-fetch port.

---
 rtl/pc_sequencer_if.sv | 35 +++
 rtl/pc_sequencer.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/pc_sequencer_if.sv
// Fetch-side bundle of pc_sequencer: redirect channels, predictor hints, fetch handshake and status.
// master is the sequencer's view; slave is the view of the stages that feed it.
interface pc_sequencer_if #(
  parameter int AW        = 32,
  parameter int NRED      = 4,
  parameter int RAS_DEPTH = 8
);
  localparam int SW = (NRED > 1) ? $clog2(NRED) : 1;
  localparam int CW = $clog2(RAS_DEPTH) + 1;

  logic [NRED-1:0]    redirect_valid;
  logic [NRED*AW-1:0] redirect_pc;
  logic               pred_take_F;
  logic [AW-1:0]      pred_pc_F;
  logic               is_call_F;
  logic               is_ret_F;
  logic               fetch_ready;
  logic               fetch_valid;
  logic [AW-1:0]      pc_F;
  logic               pending;
  logic [SW-1:0]      redirect_sel;
  logic [CW-1:0]      ras_count;

  modport master (
    input  redirect_valid, redirect_pc, pred_take_F, pred_pc_F,
           is_call_F, is_ret_F, fetch_ready,
    output fetch_valid, pc_F, pending, redirect_sel, ras_count
  );

  modport slave (
    output redirect_valid, redirect_pc, pred_take_F, pred_pc_F,
           is_call_F, is_ret_F, fetch_ready,
    input  fetch_valid, pc_F, pending, redirect_sel, ras_count
  );
endinterface

// File: rtl/pc_sequencer.sv
// Fetch-stage next-PC sequencer: prioritised redirects (held across stalls), RAS, predictor, increment.
// The return-address stack is built only when PC_SEQ_RAS_EN is defined.
module pc_sequencer #(
  parameter int            AW        = 32,
  parameter logic [AW-1:0] RESET_PC  = 32'h0000_3000,
  parameter int            NRED      = 4,
  parameter int            INC       = 4,
  parameter int            RET_OFF   = 8,
  parameter int            RAS_DEPTH = 8
) (
  input logic           clk,
  input logic           rst,
  pc_sequencer_if.master bus
);
  localparam int SW = (NRED > 1) ? $clog2(NRED) : 1;
  localparam int CW = $clog2(RAS_DEPTH) + 1;

  logic          fetch_valid_q;
  logic [AW-1:0] pc_q;
  logic [AW-1:0] pc_next;
  logic          held_valid;
  logic [SW-1:0] held_ch;
  logic [AW-1:0] held_pc;
  logic [SW-1:0] sel_q;

  logic          live_valid;
  logic [SW-1:0] live_ch;
  logic [AW-1:0] live_pc;
  logic          live_wins;
  logic          eff_valid;
  logic [SW-1:0] eff_ch;
  logic [AW-1:0] eff_pc;
  logic          apply;
  logic          latch;
  logic          seq_step;
  logic          ret_hit;
  logic [AW-1:0] ras_top;

  // NOTE: every always_comb output gets a default before any branch, so no latch is inferred.
  always_comb begin
    live_valid = 1'b0;
    live_ch    = '0;
    live_pc    = '0;
    // Scan high to low so the lowest-index request is the one left standing.
    for (int i = NRED - 1; i >= 0; i--) begin
      if (bus.redirect_valid[i]) begin
        live_valid = 1'b1;
        live_ch    = SW'(i);
        live_pc    = bus.redirect_pc[i*AW +: AW];
      end
    end
  end

  assign live_wins = live_valid && (!held_valid || (live_ch <= held_ch));
  assign eff_valid = live_valid || held_valid;
  assign eff_ch    = live_wins ? live_ch : held_ch;
  assign eff_pc    = live_wins ? live_pc : held_pc;
  assign apply     = bus.fetch_ready && eff_valid;
  assign latch     = !bus.fetch_ready && live_wins;
  assign seq_step  = fetch_valid_q && bus.fetch_ready && !eff_valid;

  always_comb begin
    pc_next = pc_q;
    if (apply) begin
      pc_next = eff_pc;
    end else if (seq_step) begin
      if (ret_hit)               pc_next = ras_top;
      else if (bus.pred_take_F)  pc_next = bus.pred_pc_F;
      else                       pc_next = pc_q + AW'(INC);
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_valid_q <= 1'b0;
      pc_q          <= RESET_PC;
      held_valid    <= 1'b0;
      held_ch       <= '0;
      held_pc       <= '0;
      sel_q         <= '0;
    end else begin
      fetch_valid_q <= 1'b1;
      pc_q          <= pc_next;
      if (apply) begin
        held_valid <= 1'b0;
        sel_q      <= eff_ch;
      end else if (latch) begin
        held_valid <= 1'b1;
        held_ch    <= live_ch;
        held_pc    <= live_pc;
        sel_q      <= live_ch;
      end
    end
  end

`ifdef PC_SEQ_RAS_EN
  localparam int PW = $clog2(RAS_DEPTH);

  logic [AW-1:0] ras_mem [RAS_DEPTH];
  logic [PW-1:0] ras_ptr;
  logic [PW-1:0] top_idx;
  logic [CW-1:0] ras_cnt;
  logic          push;
  logic          pop;

  assign top_idx = ras_ptr - 1'b1;
  assign ras_top = ras_mem[top_idx];
  assign ret_hit = bus.is_ret_F && (ras_cnt != '0);
  assign push    = seq_step && bus.is_call_F;
  assign pop     = seq_step && ret_hit;

  // A full stack keeps wrapping the pointer, so the oldest entry is the one overwritten.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ras_ptr <= '0;
      ras_cnt <= '0;
    end else if (apply && (eff_ch == '0)) begin
      ras_cnt <= '0;
    end else if (push && !pop) begin
      ras_ptr <= ras_ptr + 1'b1;
      if (ras_cnt != CW'(RAS_DEPTH)) ras_cnt <= ras_cnt + 1'b1;
    end else if (pop && !push) begin
      ras_ptr <= top_idx;
      ras_cnt <= ras_cnt - 1'b1;
    end
  end

  // NOTE: stack storage has no reset; ras_cnt alone decides which entries are meaningful.
  always_ff @(posedge clk) begin
    if (push) ras_mem[pop ? top_idx : ras_ptr] <= pc_q + AW'(RET_OFF);
  end

  assign bus.ras_count = ras_cnt;
`else
  wire [AW+1:0] unused_ras = {bus.is_call_F, bus.is_ret_F, AW'(RET_OFF)};

  assign ret_hit       = 1'b0;
  assign ras_top       = '0;
  assign bus.ras_count = '0;
`endif

  assign bus.fetch_valid  = fetch_valid_q;
  assign bus.pc_F         = pc_q;
  assign bus.pending      = held_valid;
  assign bus.redirect_sel = sel_q;
endmodule
